alu_exec_unit: RTL and testbench

- Execute-stage ALU of the single-cycle RISC-V core; consumes the 3-bit ALU control code produced by the ALU control decoder and operands from the register file / immediate mux.
- Logic and arithmetic ops resolve combinationally in one cycle.
- MUL (code 101) runs on a sequential shift-add engine; the unit asserts stall so the core holds PC and operands until the product is ready.

---
 rtl/alu_exec_unit_pkg.sv | 23 ++
 rtl/alu_exec_unit_if.sv | 31 +++
 rtl/alu_exec_unit_mul.sv | 100 ++++++++++
 rtl/alu_exec_unit.sv | 64 ++++++
 tb/tb_alu_exec_unit.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute-stage ALU.
// - alu_op_e    : 3-bit ALU control codes, shared with the ALU control decoder.
// - mul_state_e : state encoding of the sequential shift-add multiplier.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SRL = 3'b011,
    ALU_SLT = 3'b100,
    ALU_MUL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Core <-> execute-stage ALU bus.
// Signals:
//   req         core -> ALU  instruction valid in execute
//   alu_control core -> ALU  3-bit operation code
//   a, b        core -> ALU  operands
//   result      ALU -> core  operation result
//   zero        ALU -> core  result == 0
//   stall       ALU -> core  multiply in progress; core holds PC and inputs
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             req;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             stall;

  modport master (
    output req, alu_control, a, b,
    input  result, zero, stall
  );

  modport slave (
    input  req, alu_control, a, b,
    output result, zero, stall
  );

endinterface

// File: rtl/alu_exec_unit_mul.sv
// Sequential shift-add multiplier (low WIDTH bits of a*b).
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   i_start   MUL instruction present (req && op == MUL); dropping it aborts
//   i_a, i_b  multiplicand / multiplier, held stable by the core while stalled
//   o_acc     accumulator (the product once in DONE)
//   o_stall   high in IDLE/BUSY while i_start is high
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_stall
);

  localparam int unsigned CW = $clog2(WIDTH);

  mul_state_e       r_state;
  mul_state_e       w_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_mplier_nxt;

  assign w_mplier_nxt = r_mplier >> 1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start)
          w_next = (EARLY_OUT && (i_b == '0)) ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (!i_start)
          w_next = ST_IDLE;
        else if ((r_cnt == CW'(WIDTH - 1)) || (EARLY_OUT && (w_mplier_nxt == '0)))
          w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Stall is combinational so the core freezes in the very cycle the MUL
  // arrives and releases in the cycle an abort is seen.
  always_comb begin
    o_stall = 1'b0;
    o_acc   = r_acc;
    if (!rst) begin
      unique case (r_state)
        ST_IDLE, ST_BUSY: o_stall = i_start;
        default:          o_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= '0;
          end
        end
        ST_BUSY: begin
          if (i_start) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: combinational logic/arithmetic ops plus a stalling
// sequential multiplier for op code MUL.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       alu_exec_unit_if.slave: req, alu_control, a, b in;
//             result, zero, stall out
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  alu_exec_unit_if.slave    bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_op_e          w_op;
  logic             w_start;
  logic [WIDTH-1:0] w_acc;
  logic             w_stall;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_result;

  assign w_op    = alu_op_e'(bus.alu_control);
  assign w_start = bus.req && (w_op == ALU_MUL);

  shift_add_multiplier #(
    .WIDTH     (WIDTH),
    .EARLY_OUT (EARLY_OUT)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_a     (bus.a),
    .i_b     (bus.b),
    .o_acc   (w_acc),
    .o_stall (w_stall)
  );

  always_comb begin
    w_res = '0;
    unique case (w_op)
      ALU_AND: w_res = bus.a & bus.b;
      ALU_OR:  w_res = bus.a | bus.b;
      ALU_ADD: w_res = bus.a + bus.b;
      ALU_SUB: w_res = bus.a - bus.b;
      ALU_SLL: w_res = bus.a << bus.b[SHW-1:0];
      ALU_SRL: w_res = bus.a >> bus.b[SHW-1:0];
      ALU_SLT: w_res[0] = ($signed(bus.a) < $signed(bus.b));
      ALU_MUL: w_res = w_acc;
      default: w_res = '0;
    endcase
  end

  // Result is forced to zero while reset is held so branch logic sees zero=1.
  assign w_result   = rst ? '0 : w_res;
  assign bus.result = w_result;
  assign bus.zero   = (w_result == '0);
  assign bus.stall  = w_stall;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(32)) bus  ();
  alu_exec_unit_if #(.WIDTH(32)) bus0 ();

  alu_exec_unit #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_exec_unit #(.WIDTH(32), .EARLY_OUT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic comb_op(input string tag, input alu_op_e op, input logic [31:0] ta,
                         input logic [31:0] tb_v, input logic [31:0] exp, input logic ez);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.alu_control = op; bus.a = ta; bus.b = tb_v;
    @(negedge clk);
    check_eq({tag, "_res"},   bus.result, exp);
    check_eq({tag, "_zero"},  {31'd0, bus.zero}, {31'd0, ez});
    check_eq({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
  endtask

  // Starts a MUL in the next cycle, counts stall cycles until the DONE cycle,
  // then checks result/zero in that DONE cycle.
  task automatic mul_run(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input int exp_stall, input logic [31:0] exp_res);
    int n    = 0;
    bit done = 1'b0;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.alu_control = ALU_MUL; bus.a = ta; bus.b = tb_v;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.stall) n++;
      else done = 1'b1;
    end
    check_eq({tag, "_done"},  {31'd0, done}, 32'd1);
    check_eq({tag, "_stall"}, n, exp_stall);
    check_eq({tag, "_res"},   bus.result, exp_res);
    check_eq({tag, "_zero"},  {31'd0, bus.zero}, {31'd0, (exp_res == 32'd0)});
  endtask

  initial begin
    int  n0;
    bit  done0;
    rst = 1'b1;
    bus.req = 1'b0; bus.alu_control = ALU_ADD; bus.a = 32'd5; bus.b = 32'd3;
    bus0.req = 1'b0; bus0.alu_control = ALU_AND; bus0.a = '0; bus0.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_res",   bus.result, 32'd0);
    check_eq("rst_zero",  {31'd0, bus.zero}, 32'd1);
    check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    comb_op("add",  ALU_ADD, 32'd7,          32'd5,  32'd12,         1'b0);
    comb_op("sub",  ALU_SUB, 32'd5,          32'd7,  32'hFFFF_FFFE,  1'b0);
    comb_op("and",  ALU_AND, 32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000, 1'b0);
    comb_op("or",   ALU_OR,  32'h0000_F0F0,  32'h0000_0F0F, 32'h0000_FFFF, 1'b0);
    comb_op("sll",  ALU_SLL, 32'd1,          32'd31, 32'h8000_0000,  1'b0);
    comb_op("srl",  ALU_SRL, 32'h8000_0000,  32'd4,  32'h0800_0000,  1'b0);
    comb_op("slt",  ALU_SLT, 32'hFFFF_FFFF,  32'd1,  32'd1,          1'b0);
    comb_op("sltn", ALU_SLT, 32'd1,  32'hFFFF_FFFF,  32'd0,          1'b1);
    comb_op("subz", ALU_SUB, 32'd9,          32'd9,  32'd0,          1'b1);

    mul_run("mul3x5", 32'd3, 32'd5, 4, 32'd15);
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(negedge clk);
    check_eq("mul3x5_idle_stall", {31'd0, bus.stall}, 32'd0);

    mul_run("mul_big", 32'h0001_0000, 32'h0001_0000, 18, 32'd0);
    mul_run("mul7x0",  32'd7, 32'd0, 1, 32'd0);
    mul_run("b2b_6x7", 32'd6, 32'd7, 4, 32'd42);
    mul_run("b2b_2x3", 32'd2, 32'd3, 3, 32'd6);

    // reset during the third BUSY cycle
    @(posedge clk); #1;
    bus.req = 1'b1; bus.alu_control = ALU_MUL; bus.a = 32'hFFFF; bus.b = 32'hFFFF;
    @(negedge clk);
    check_eq("rstab_idle_stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstab_stall", {31'd0, bus.stall}, 32'd0);
    check_eq("rstab_res",   bus.result, 32'd0);
    check_eq("rstab_zero",  {31'd0, bus.zero}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; bus.req = 1'b0;
    mul_run("after_rst_2x2", 32'd2, 32'd2, 3, 32'd4);

    // req dropped during BUSY
    @(posedge clk); #1;
    bus.req = 1'b1; bus.alu_control = ALU_MUL; bus.a = 32'hFFFF; bus.b = 32'hFFFF;
    @(posedge clk);
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(negedge clk);
    check_eq("reqab_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("reqab_idle_stall", {31'd0, bus.stall}, 32'd0);
    mul_run("after_req_5x3", 32'd5, 32'd3, 3, 32'd15);

    // full-length multiply without early termination
    n0 = 0; done0 = 1'b0;
    @(posedge clk); #1;
    bus0.req = 1'b1; bus0.alu_control = ALU_MUL; bus0.a = 32'hFFFF_FFFF; bus0.b = 32'hFFFF_FFFF;
    for (int i = 0; i < 100 && !done0; i++) begin
      @(negedge clk);
      if (bus0.stall) n0++;
      else done0 = 1'b1;
    end
    check_eq("full_done",  {31'd0, done0}, 32'd1);
    check_eq("full_stall", n0, 33);
    check_eq("full_res",   bus0.result, 32'd1);
    check_eq("full_zero",  {31'd0, bus0.zero}, 32'd0);
    @(posedge clk); #1;
    bus0.req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
